// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: stores one sample per handshake, then runs a single shared
// multiply-accumulate over all taps, one tap per clock, and presents a scaled, saturated result.
module fir_mac_sequencer #(
  parameter int WIDTH = 8,
  parameter int NTAPS = 16,
  parameter int FRAC  = 8
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic [WIDTH-1:0]         xn,
  input  logic                     xn_valid,
  output logic                     xn_ready,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [WIDTH-1:0]         coef_data,
  output logic [WIDTH-1:0]         yn,
  output logic                     yn_valid,
  input  logic                     yn_ready,
  output logic                     busy
);

  localparam int PW = $clog2(NTAPS);
  localparam int AW = 2 * WIDTH + PW;
  localparam logic [PW:0]   NTAPS_W = (PW + 1)'(NTAPS);
  localparam logic [PW-1:0] LAST    = PW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   x_buf [NTAPS];
  logic [WIDTH-1:0]   c_reg [NTAPS];
  logic [PW-1:0]      wr_ptr, k, tap_idx;
  logic [PW:0]        wrap_idx;
  logic [AW-1:0]      acc, acc_nxt;
  logic [2*WIDTH-1:0] prod;
  logic               coef_ok, last_tap;

  function automatic logic [WIDTH-1:0] scale_sat(input logic [AW-1:0] v);
    logic [AW-1:0] s;
    s = v >> FRAC;
    if (|s[AW-1:WIDTH]) return {WIDTH{1'b1}};
    return s[WIDTH-1:0];
  endfunction

  // Tap k reads the sample k positions older than the newest, wrapping around the buffer
  assign wrap_idx = {1'b0, wr_ptr} + NTAPS_W - {1'b0, k};
  assign tap_idx  = (wr_ptr >= k) ? (wr_ptr - k) : wrap_idx[PW-1:0];
  assign prod     = (2 * WIDTH)'(x_buf[tap_idx]) * (2 * WIDTH)'(c_reg[k]);
  assign acc_nxt  = acc + AW'(prod);
  assign last_tap = (k == LAST);
  assign coef_ok  = (state == IDLE) && coef_we && ({1'b0, coef_addr} < NTAPS_W);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    xn_ready  = 1'b0;
    yn_valid  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        xn_ready = 1'b1;
        busy     = 1'b0;
        if (xn_valid) state_nxt = MAC;
      end
      MAC: if (last_tap) state_nxt = OUT;
      OUT: begin
        yn_valid = 1'b1;
        if (yn_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: sample capture, tap sequencing, result load and pointer advance
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_buf[i] <= '0;
        c_reg[i] <= '0;
      end
      acc    <= '0;
      k      <= '0;
      wr_ptr <= '0;
      yn     <= '0;
    end else begin
      if (coef_ok) c_reg[coef_addr] <= coef_data;
      case (state)
        IDLE: if (xn_valid) begin
          x_buf[wr_ptr] <= xn;
          acc           <= '0;
          k             <= '0;
        end
        MAC: begin
          acc <= acc_nxt;
          k   <= last_tap ? '0 : k + PW'(1);
          if (last_tap) yn <= scale_sat(acc_nxt);
        end
        OUT: if (yn_ready) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        default: ;
      endcase
    end
  end

endmodule
